// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_DSTREAK_DEF = 4;
    localparam int DSTREAK_W       = 3;
    localparam int STALL_W         = 16;

    // Which requester owns the read response arriving next cycle
    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_IF_PEND = 2'd1,
        OWN_DM_PEND = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter onto one single-cycle-latency memory.
// Data side wins by default; fetch is forced through after MAX_DSTREAK
// consecutive data grants while it waits.
//
// state        | meaning
// OWN_NONE     | no read response due next cycle
// OWN_IF_PEND  | mem_rdata next cycle belongs to fetch
// OWN_DM_PEND  | mem_rdata next cycle belongs to data port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_wen,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic [STALL_W-1:0]  stall_cnt
);

    logic [DSTREAK_W-1:0] dstreak;
    logic                 streak_hit;
    owner_e               owner;

    assign streak_hit = (dstreak == DSTREAK_W'(MAX_DSTREAK));

    // Grants are combinational; reset blocks both so nothing reaches memory
    assign if_gnt   = ~reset & if_req & (~dm_req | streak_hit);
    assign dm_gnt   = ~reset & dm_req & ~(if_req & streak_hit);
    assign stall_if = if_req & ~if_gnt;
    assign mem_en   = if_gnt | dm_gnt;

    // Request mux onto the memory port; idle port drives zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_wen   = dm_wen;
        end
    end

    // Pending-owner FSM: records who gets the read data next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else if (if_gnt) begin
            owner <= OWN_IF_PEND;
        end else if (dm_gnt && !dm_wen) begin
            owner <= OWN_DM_PEND;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // Response steering; a response still in flight when reset rises is dropped
    assign if_rvalid = ~reset & (owner == OWN_IF_PEND);
    assign dm_rvalid = ~reset & (owner == OWN_DM_PEND);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    // Consecutive data grants while fetch is waiting
    always_ff @(posedge clk) begin
        if (reset || if_gnt || !if_req) begin
            dstreak <= '0;
        end else if (dm_gnt) begin
            dstreak <= dstreak + 1'b1;
        end
    end

    // Saturating fetch-stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized checks of mem_port_arbiter against a
// behavioural model of the arbitration rules and a sparse memory.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req, dm_req, dm_wen;
    logic [AW-1:0]   if_addr, dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [DW-1:0]   if_rdata, dm_rdata, mem_wdata;
    logic            mem_en, mem_wen, stall_if;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_cnt(stall_cnt)
    );

    // Environment memory: unwritten words read back as address + 3
    logic [DW-1:0] env_mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) env_mem[mem_addr] = mem_wdata;
            else mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : DW'(mem_addr + 32'd3);
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            m_streak = 0;
    int            m_pend   = 0;      // 0 none, 1 fetch, 2 data
    logic [DW-1:0] m_pend_data = '0;
    int            m_cnt    = 0;
    bit            g_if = 1'b0, g_dm = 1'b0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : DW'(a + 32'd3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check every output against the model, then advance the model
    task automatic cycle();
        bit            e_if, e_dm, e_stall, e_wen, e_ifv, e_dmv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #1;
        if (reset) begin
            e_if = 1'b0;
            e_dm = 1'b0;
        end else begin
            e_if = if_req && (!dm_req || m_streak == MAXD);
            e_dm = dm_req && !e_if;
        end
        e_stall = if_req && !e_if;
        e_addr  = e_if ? if_addr : (e_dm ? dm_addr : '0);
        e_wd    = e_dm ? dm_wdata : '0;
        e_wen   = e_dm && dm_wen;
        e_ifv   = !reset && m_pend == 1;
        e_dmv   = !reset && m_pend == 2;
        chk("if_gnt",    64'(if_gnt),    64'(e_if));
        chk("dm_gnt",    64'(dm_gnt),    64'(e_dm));
        chk("mem_en",    64'(mem_en),    64'(e_if | e_dm));
        chk("mem_wen",   64'(mem_wen),   64'(e_wen));
        chk("mem_addr",  64'(mem_addr),  64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        chk("stall_if",  64'(stall_if),  64'(e_stall));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
        chk("if_rdata",  64'(if_rdata),  64'(e_ifv ? m_pend_data : '0));
        chk("dm_rvalid", 64'(dm_rvalid), 64'(e_dmv));
        chk("dm_rdata",  64'(dm_rdata),  64'(e_dmv ? m_pend_data : '0));
        @(posedge clk);
        if (reset) begin
            m_streak = 0;
            m_pend   = 0;
            m_cnt    = 0;
        end else begin
            if (e_if || !if_req) m_streak = 0;
            else if (e_dm) m_streak++;
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (e_if) begin
                m_pend = 1;
                m_pend_data = ref_rd(if_addr);
            end else if (e_dm && !dm_wen) begin
                m_pend = 2;
                m_pend_data = ref_rd(dm_addr);
            end else begin
                m_pend = 0;
            end
            if (e_dm && dm_wen) ref_mem[dm_addr] = dm_wdata;
        end
        g_if = e_if;
        g_dm = e_dm;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wen = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with requests pending that must not be granted
        if_req = 1'b1; dm_req = 1'b1;
        cycle();
        if_req = 1'b0; dm_req = 1'b0;
        cycle();
        reset = 1'b0;

        // Fetch only: grant now, data 0x13 next cycle
        if_req = 1'b1; if_addr = 32'h10;
        cycle();
        if_req = 1'b0;
        #1;
        chk("fetch_rvalid", 64'(if_rvalid), 64'd1);
        chk("fetch_rdata",  64'(if_rdata),  64'h13);
        cycle();

        // Simultaneous: data wins, fetch stalls once, then fetch goes
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h100;
        #1;
        chk("sim_dm_gnt", 64'(dm_gnt),   64'd1);
        chk("sim_stall",  64'(stall_if), 64'd1);
        cycle();
        dm_req = 1'b0;
        #1;
        chk("sim_if_gnt",    64'(if_gnt),    64'd1);
        chk("sim_dm_rvalid", 64'(dm_rvalid), 64'd1);
        chk("sim_stall_cnt", 64'(stall_cnt), 64'd1);
        cycle();
        if_req = 1'b0;
        cycle();

        // Starvation guard: 4 data grants, then fetch, then data again
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h104;
        for (int i = 0; i < MAXD; i++) begin
            #1;
            chk("starve_dm_gnt", 64'(dm_gnt), 64'd1);
            cycle();
        end
        #1;
        chk("starve_if_gnt", 64'(if_gnt), 64'd1);
        chk("starve_dm_off", 64'(dm_gnt), 64'd0);
        cycle();
        #1;
        chk("streak_cleared", 64'(dm_gnt), 64'd1);
        cycle();
        if_req = 1'b0; dm_req = 1'b0;
        cycle();

        // Write completes in the grant cycle, no response
        dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_mem_wen",   64'(mem_wen),   64'd1);
        chk("wr_mem_addr",  64'(mem_addr),  64'h200);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        cycle();
        dm_wen = 1'b0;
        #1;
        chk("wr_no_rvalid", 64'(dm_rvalid), 64'd0);
        cycle();
        dm_req = 1'b0;
        #1;
        chk("wr_readback", 64'(dm_rdata), 64'hDEADBEEF);
        cycle();

        // Reset lands while a data read response is due
        dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h300;
        cycle();
        dm_req = 1'b0; reset = 1'b1;
        #1;
        chk("rst_rvalid", 64'(dm_rvalid), 64'd0);
        cycle();
        reset = 1'b0;
        #1;
        chk("rst_after_rvalid", 64'(dm_rvalid), 64'd0);
        chk("rst_after_cnt",    64'(stall_cnt), 64'd0);
        cycle();

        // Read requested during reset leaves nothing behind
        reset = 1'b1; dm_req = 1'b1;
        cycle();
        reset = 1'b0; dm_req = 1'b0;
        cycle();

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            if (!(if_req && !g_if)) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!(dm_req && !g_dm)) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_wen   = ($urandom_range(0, 2) == 0);
                dm_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                dm_wdata = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
